// File: rtl/pla_pkg.sv
// pla_pkg: shared definitions for the runtime-programmable PLA.
//   - pla_state_e : configuration FSM states (PLA_IDLE, PLA_COPY)
//   - LIT_POS/NEG : bit offset of the true/complement literal inside an AND-row pair
//   - pla_cfg_w() : configuration data width, max(2*IN_WIDTH, TERMS)
package pla_pkg;

    typedef enum logic {
        PLA_IDLE = 1'b0,
        PLA_COPY = 1'b1
    } pla_state_e;

    // AND row bit 2i+LIT_POS requires in[i]=1, bit 2i+LIT_NEG requires in[i]=0.
    localparam int LIT_POS = 0;
    localparam int LIT_NEG = 1;

    function automatic int pla_cfg_w(input int in_width, input int terms);
        return (2 * in_width > terms) ? 2 * in_width : terms;
    endfunction

endpackage

// File: rtl/pla_plane.sv
// pla_plane: shadow/active storage pair for one PLA plane.
// Rows are addressed in the global configuration address space starting at BASE.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_wr_en/i_wr_addr/data  shadow row write (ignored if the address is not ours)
//   i_cp_en/i_cp_addr       copy one shadow row into the active plane
//   o_active                active rows, consumed by the evaluation logic
module pla_plane #(
    parameter int ROWS = 8,
    parameter int W    = 8,
    parameter int AW   = 4,
    parameter int BASE = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_cp_en,
    input  logic [AW-1:0] i_cp_addr,
    output logic [W-1:0]  o_active [ROWS]
);

    logic [W-1:0] r_shadow [ROWS];
    logic [W-1:0] r_active [ROWS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < ROWS; r++) begin
                r_shadow[r] <= '0;
                r_active[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (i_wr_en && (i_wr_addr == AW'(BASE + r))) r_shadow[r] <= i_wr_data;
                if (i_cp_en && (i_cp_addr == AW'(BASE + r))) r_active[r] <= r_shadow[r];
            end
        end
    end

    assign o_active = r_active;

endmodule

// File: rtl/pla_prog.sv
// pla_prog: runtime-programmable registered PLA.
// AND/OR planes (and the polarity row when PLA_PROG_POLARITY_EN is defined) are
// written into shadow storage over a valid/ready port, then copied one row per
// cycle into the active planes on a commit request.
// Ports:
//   clk, rst                clock, asynchronous active-high reset
//   pla_in / pla_out        logic inputs / registered outputs (1-cycle latency)
//   out_valid               pla_out reflects a committed, stable configuration
//   cfg_valid/cfg_ready     write handshake; cfg_addr row address, cfg_data row data
//   cfg_commit              request shadow-to-active copy
//   cfg_busy                copy in progress
//   cfg_err                 sticky: write to an unmapped address (cleared by a copy)
//   dbg_state               current FSM state
// Handshake: a write completes on the rising clock edge where cfg_valid and
// cfg_ready are both high; cfg_ready depends only on the registered FSM state.
module pla_prog
    import pla_pkg::*;
#(
    parameter int  IN_WIDTH  = 4,
    parameter int  OUT_WIDTH = 4,
    parameter int  TERMS     = 8,
    localparam int CFG_W     = pla_cfg_w(IN_WIDTH, TERMS),
    localparam int AW        = $clog2(TERMS + OUT_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  pla_in,
    output logic [OUT_WIDTH-1:0] pla_out,
    output logic                 out_valid,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [CFG_W-1:0]     cfg_data,
    input  logic                 cfg_commit,
    output logic                 cfg_busy,
    output logic                 cfg_err,
    output pla_state_e           dbg_state
);

`ifdef PLA_PROG_POLARITY_EN
    localparam int NROWS = TERMS + OUT_WIDTH + 1;
`else
    localparam int NROWS = TERMS + OUT_WIDTH;
`endif

    pla_state_e           r_state;
    pla_state_e           w_next_state;
    logic [AW-1:0]        r_cnt;
    logic                 r_err;
    logic [OUT_WIDTH-1:0] r_out;

    logic                    w_wr_fire;
    logic                    w_mapped;
    logic                    w_wr_en;
    logic                    w_cp_en;
    logic                    w_last;
    logic [2*IN_WIDTH-1:0]   w_and [TERMS];
    logic [TERMS-1:0]        w_or  [OUT_WIDTH];
    logic [OUT_WIDTH-1:0]    w_pol;
    logic [TERMS-1:0]        w_term;
    logic [OUT_WIDTH-1:0]    w_eval;

    assign w_wr_fire = cfg_valid & cfg_ready;
    assign w_mapped  = (cfg_addr < AW'(NROWS));
    assign w_wr_en   = w_wr_fire & w_mapped;
    assign w_cp_en   = (r_state == PLA_COPY);
    assign w_last    = (r_cnt == AW'(NROWS - 1));

    pla_plane #(.ROWS(TERMS), .W(2*IN_WIDTH), .AW(AW), .BASE(0)) u_and_plane (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(w_wr_en), .i_wr_addr(cfg_addr), .i_wr_data(cfg_data[2*IN_WIDTH-1:0]),
        .i_cp_en(w_cp_en), .i_cp_addr(r_cnt), .o_active(w_and)
    );

    pla_plane #(.ROWS(OUT_WIDTH), .W(TERMS), .AW(AW), .BASE(TERMS)) u_or_plane (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(w_wr_en), .i_wr_addr(cfg_addr), .i_wr_data(cfg_data[TERMS-1:0]),
        .i_cp_en(w_cp_en), .i_cp_addr(r_cnt), .o_active(w_or)
    );

`ifdef PLA_PROG_POLARITY_EN
    logic [OUT_WIDTH-1:0] w_pol_row [1];

    pla_plane #(.ROWS(1), .W(OUT_WIDTH), .AW(AW), .BASE(TERMS + OUT_WIDTH)) u_pol_plane (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(w_wr_en), .i_wr_addr(cfg_addr), .i_wr_data(cfg_data[OUT_WIDTH-1:0]),
        .i_cp_en(w_cp_en), .i_cp_addr(r_cnt), .o_active(w_pol_row)
    );
    assign w_pol = w_pol_row[0];
`else
    assign w_pol = '0;
`endif

    // FSM state register, copy row counter and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PLA_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == PLA_COPY) && !w_last) r_cnt <= r_cnt + AW'(1);
            else                                  r_cnt <= '0;
            // Unmapped writes can only complete in IDLE, so they never race the clear.
            if ((r_state == PLA_COPY) && w_last) r_err <= 1'b0;
            else if (w_wr_fire && !w_mapped)     r_err <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            PLA_IDLE: if (cfg_commit) w_next_state = PLA_COPY;
            PLA_COPY: if (w_last)     w_next_state = PLA_IDLE;
            default:                  w_next_state = PLA_IDLE;
        endcase
    end

    // Term evaluation: a selected literal that is not satisfied kills the term,
    // so an empty row is constant 1 and a row selecting both literals is 0.
    always_comb begin
        w_term = '1;
        for (int t = 0; t < TERMS; t++) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (w_and[t][2*i+LIT_POS] && !pla_in[i]) w_term[t] = 1'b0;
                if (w_and[t][2*i+LIT_NEG] &&  pla_in[i]) w_term[t] = 1'b0;
            end
        end
        w_eval = '0;
        for (int o = 0; o < OUT_WIDTH; o++) begin
            w_eval[o] = (|(w_term & w_or[o])) ^ w_pol[o];
        end
    end

    // Output register is frozen while the active planes are partially updated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      r_out <= '0;
        else if (r_state == PLA_IDLE) r_out <= w_eval;
    end

    assign pla_out   = r_out;
    assign out_valid = (r_state == PLA_IDLE);
    assign cfg_ready = (r_state == PLA_IDLE);
    assign cfg_busy  = (r_state == PLA_COPY);
    assign cfg_err   = r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_pla_prog.sv
module tb_pla_prog;
  import pla_pkg::*;

  localparam int IN_W  = 4;
  localparam int OUT_W = 4;
  localparam int TERMS = 8;
  localparam int AW    = 4;
`ifdef PLA_PROG_POLARITY_EN
  localparam int NROWS = TERMS + OUT_W + 1;
`else
  localparam int NROWS = TERMS + OUT_W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [IN_W-1:0]  pla_in = '0;
  logic [OUT_W-1:0] pla_out;
  logic             out_valid;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [AW-1:0]    cfg_addr = '0;
  logic [7:0]       cfg_data = '0;
  logic             cfg_commit = 1'b0;
  logic             cfg_busy;
  logic             cfg_err;
  pla_state_e       dbg_state;

  pla_prog dut (
    .clk(clk), .rst(rst),
    .pla_in(pla_in), .pla_out(pla_out), .out_valid(out_valid),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  logic [7:0] sh_and [TERMS];
  logic [7:0] ac_and [TERMS];
  logic [7:0] sh_or  [OUT_W];
  logic [7:0] ac_or  [OUT_W];
  logic [3:0] sh_pol, ac_pol;
  logic       m_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  function automatic void model_clear();
    for (int t = 0; t < TERMS; t++) begin sh_and[t] = '0; ac_and[t] = '0; end
    for (int o = 0; o < OUT_W; o++) begin sh_or[o] = '0; ac_or[o] = '0; end
    sh_pol = '0; ac_pol = '0; m_err = 1'b0;
  endfunction

  function automatic void model_commit();
    for (int t = 0; t < TERMS; t++) ac_and[t] = sh_and[t];
    for (int o = 0; o < OUT_W; o++) ac_or[o] = sh_or[o];
    ac_pol = sh_pol;
    m_err  = 1'b0;
  endfunction

  // A product term is true when every requested literal holds.
  function automatic bit term_true(int t, logic [3:0] x);
    for (int i = 0; i < IN_W; i++) begin
      if (ac_and[t][2*i]   == 1'b1 && x[i] == 1'b0) return 1'b0;
      if (ac_and[t][2*i+1] == 1'b1 && x[i] == 1'b1) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] model_eval(logic [3:0] x);
    logic [3:0] y;
    y = '0;
    for (int o = 0; o < OUT_W; o++) begin
      bit acc;
      acc = 1'b0;
      for (int t = 0; t < TERMS; t++)
        if (ac_or[o][t] && term_true(t, x)) acc = 1'b1;
      y[o] = acc ^ ac_pol[o];
    end
    return y;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] data);
    check("wr_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_valid = 1'b0;
    if (addr < TERMS)              sh_and[addr] = data;
    else if (addr < TERMS + OUT_W) sh_or[addr - TERMS] = data;
`ifdef PLA_PROG_POLARITY_EN
    else if (addr == TERMS + OUT_W) sh_pol = data[3:0];
`endif
    else m_err = 1'b1;
    check("wr_err", 32'(cfg_err), 32'(m_err));
  endtask

  // Commit with pla_in held at x; checks busy length, frozen output and the
  // exact cycle the new configuration appears.
  task automatic do_commit(input logic [3:0] x);
    logic [3:0] old_v;
    int n;
    pla_in = x;
    tick();
    old_v = model_eval(x);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n = 0;
    while (cfg_busy && n < 50) begin
      check("copy_out_valid", 32'(out_valid), 32'd0);
      check("copy_frozen", 32'(pla_out), 32'(old_v));
      n++;
      tick();
    end
    check("busy_len", n, NROWS);
    check("post_out_valid", 32'(out_valid), 32'd1);
    check("pre_visible", 32'(pla_out), 32'(old_v));
    model_commit();
    tick();
    check("new_visible", 32'(pla_out), 32'(model_eval(x)));
    check("post_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic check_in(input string tag, input logic [3:0] x);
    pla_in = x;
    tick();
    check(tag, 32'(pla_out), 32'(model_eval(x)));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] frozen;
    int n;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    pla_in = 4'hF;
    repeat (3) tick();
    check("rst_out", 32'(pla_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd1);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(PLA_IDLE));
    check("rst_err", 32'(cfg_err), 32'd0);

    // single literal term on out0
    do_write(4'd0, 8'h01);
    do_write(4'd8, 8'h01);
    do_commit(4'b0001);
    check_in("in0_hi", 4'b0001);
    check("in0_hi_bit", 32'(pla_out[0]), 32'd1);
    check_in("in0_lo", 4'b0000);
    check("in0_lo_bit", 32'(pla_out[0]), 32'd0);

    // contradictory term on out1, empty term on out3
    do_write(4'd1, 8'h03);
    do_write(4'd9, 8'h02);
    do_write(4'd2, 8'h00);
    do_write(4'd11, 8'h04);
    do_commit(4'h0);
    for (int v = 0; v < 16; v++) begin
      check_in("sweep", 4'(v));
      exp_q.push_back({30'd0, 1'b1, 1'b0});
      check("sweep_o1o3", {30'd0, pla_out[3], pla_out[1]}, exp_q.pop_front());
    end

    // write + commit in the same IDLE cycle: write must be included
    cfg_valid = 1'b1; cfg_addr = 4'd10; cfg_data = 8'h01; cfg_commit = 1'b1;
    pla_in = 4'b0001;
    tick();
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    sh_or[2] = 8'h01;
    n = 0;
    while (cfg_busy && n < 50) begin n++; tick(); end
    check("wc_busy_len", n, NROWS);
    model_commit();
    check_in("wc_incl", 4'b0001);

    // write and commit pulsed during COPY are ignored, output frozen
    pla_in = 4'h5;
    tick();
    frozen = model_eval(4'h5);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    n = 0;
    while (cfg_busy && n < 50) begin
      n++;
      if (n == 3) begin
        check("copy_ready", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b1; cfg_addr = 4'd0; cfg_data = 8'hAA; cfg_commit = 1'b1;
      end
      check("copy_hold", 32'(pla_out), 32'(frozen));
      pla_in = 4'($urandom_range(0, 15));
      tick();
      cfg_valid = 1'b0; cfg_commit = 1'b0;
    end
    check("copy_ign_len", n, NROWS);
    model_commit();
    for (int v = 0; v < 16; v++) check_in("copy_ign_cfg", 4'(v));

    // unmapped writes set cfg_err and change nothing; a commit clears it
    do_write(4'd15, 8'hFF);
`ifndef PLA_PROG_POLARITY_EN
    do_write(4'd12, 8'hFF);
`endif
    check("err_set", 32'(cfg_err), 32'd1);
    do_commit(4'h3);
    check("err_clr", 32'(cfg_err), 32'd0);
    for (int v = 0; v < 16; v++) check_in("err_noch", 4'(v));

    // randomized configurations
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 10; k++) begin
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, (k == 9) ? 15 : NROWS - 1));
        do_write(a, 8'($urandom_range(0, 255)));
      end
      do_commit(4'($urandom_range(0, 15)));
      for (int k = 0; k < 8; k++) check_in("rand", 4'($urandom_range(0, 15)));
    end

    // reset in the middle of a copy
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    model_clear();
    check("mrst_out", 32'(pla_out), 32'd0);
    check("mrst_busy", 32'(cfg_busy), 32'd0);
    check("mrst_state", 32'(dbg_state), 32'(PLA_IDLE));
    check("mrst_valid", 32'(out_valid), 32'd1);
    tick();
    rst = 1'b0;
    check_in("mrst_f", 4'hF);
    do_commit(4'hF);
    for (int v = 0; v < 16; v++) check_in("mrst_zero", 4'(v));

`ifdef PLA_PROG_POLARITY_EN
    do_write(4'd12, 8'hF8);
    do_commit(4'h0);
    for (int k = 0; k < 6; k++) begin
      check_in("pol", 4'($urandom_range(0, 15)));
      check("pol_bits", 32'(pla_out), 32'h8);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
